// File: rtl/ram512_ctrl.sv
// Two-requester arbiter in front of a single-port RAM, with a background zero-fill of every word.
// Grants are combinational in the request cycle; read data returns one cycle after the grant.

module ram512_ctrl #(
  parameter int DW = 16,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic [DW-1:0] ram_in,
  output logic [AW-1:0] ram_addr,
  output logic          ram_load,
  input  logic [DW-1:0] ram_out
);

  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] LAST = {1'b0, {AW{1'b1}}};

  typedef enum logic {SERVE = 1'b0, CLEAR = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] in_q;
  logic [DW-1:0] rdata_q;
  logic          rvalid0_q, rvalid1_q;
  logic          serve_en;
  logic          g0, g1;
  logic          rd_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SERVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grants are suppressed while reset is held, since they are purely combinational.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    serve_en = 1'b0;
    case (state_q)
      SERVE: begin
        if (clr_start) state_d = CLEAR;
        else           serve_en = rst_n;
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = SERVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_comb begin
    g0    = 1'b0;
    g1    = 1'b0;
    ptr_d = ptr_q;
    if (serve_en) begin
      if (req0 && req1) begin
        g0 = ~ptr_q;
        g1 = ptr_q;
      end else begin
        g0 = req0;
        g1 = req1;
      end
    end
    if (g0)      ptr_d = 1'b1;
    else if (g1) ptr_d = 1'b0;
  end

  // Address and write data hold their last driven value when idle.
  always_comb begin
    ram_addr = addr_q;
    ram_in   = in_q;
    ram_load = 1'b0;
    if (state_q == CLEAR) begin
      ram_addr = cnt_q[AW-1:0];
      ram_in   = '0;
      ram_load = 1'b1;
    end else if (g0) begin
      ram_addr = addr0;
      ram_in   = wdata0;
      ram_load = we0;
    end else if (g1) begin
      ram_addr = addr1;
      ram_in   = wdata1;
      ram_load = we1;
    end
  end

  assign rd_grant = (g0 & ~we0) | (g1 & ~we1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= 1'b0;
      addr_q    <= '0;
      in_q      <= '0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      addr_q    <= ram_addr;
      in_q      <= ram_in;
      rvalid0_q <= g0 & ~we0;
      rvalid1_q <= g1 & ~we1;
      if (rd_grant) rdata_q <= ram_out;
    end
  end

  assign gnt0     = g0;
  assign gnt1     = g1;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata    = rdata_q;
  assign clr_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_ram512_ctrl.sv
// Bench for ram512_ctrl: directed vector table, clear/reset sequences, and a randomized run
// compared against a cycle-level model with its own shadow memory.

module tb_ram512_ctrl;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int NW = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          clr_start, clr_busy;
  logic [DW-1:0] ram_in;
  logic [AW-1:0] ram_addr;
  logic          ram_load;
  logic [DW-1:0] ram_out;

  always #5 clk = ~clk;

  ram512_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_in(ram_in), .ram_addr(ram_addr), .ram_load(ram_load), .ram_out(ram_out)
  );

  // RAM: synchronous write, combinational read.
  logic [DW-1:0] ram [NW];
  always @(posedge clk) if (ram_load) ram[ram_addr] <= ram_in;
  assign ram_out = ram[ram_addr];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    clr_start = 1'b0;
  endtask

  typedef struct {
    logic r0; logic w0; logic [8:0] a0; logic [15:0] d0;
    logic r1; logic w1; logic [8:0] a1; logic [15:0] d1;
    logic g0; logic g1; logic ld; logic [8:0] ea; logic [15:0] ei;
    logic v0; logic v1; logic [15:0] rd;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic r0, input logic w0, input logic [8:0] a0, input logic [15:0] d0,
                              input logic r1, input logic w1, input logic [8:0] a1, input logic [15:0] d1,
                              input logic g0, input logic g1, input logic ld, input logic [8:0] ea,
                              input logic [15:0] ei, input logic v0, input logic v1, input logic [15:0] rd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.ld = ld; v.ea = ea; v.ei = ei;
    v.v0 = v0; v.v1 = v1; v.rd = rd;
    return v;
  endfunction

  // Reference model state
  int            m_clr_left;
  logic          m_ptr, m_rv0, m_rv1;
  logic [DW-1:0] m_rdata, m_in;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_mem [NW];
  logic          e_g0, e_g1, e_ld, e_busy;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_i;
  logic          done0, done1;
  int            busy_n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1'b1/1'b0 abbreviations keep the table readable
    tbl[0]  = mk(1'b1,1'b1,9'h1A5,16'hBEEF, 1'b0,1'b0,9'h000,16'h0000, 1'b1,1'b0,1'b1,9'h1A5,16'hBEEF, 1'b0,1'b0,16'h0000);
    tbl[1]  = mk(1'b0,1'b0,9'h000,16'h0000, 1'b1,1'b0,9'h1A5,16'h0000, 1'b0,1'b1,1'b0,9'h1A5,16'h0000, 1'b0,1'b0,16'h0000);
    tbl[2]  = mk(1'b0,1'b0,9'h000,16'h0000, 1'b0,1'b0,9'h000,16'h0000, 1'b0,1'b0,1'b0,9'h1A5,16'h0000, 1'b0,1'b1,16'hBEEF);
    tbl[3]  = mk(1'b1,1'b1,9'h010,16'h1111, 1'b1,1'b1,9'h020,16'h2222, 1'b1,1'b0,1'b1,9'h010,16'h1111, 1'b0,1'b0,16'hBEEF);
    tbl[4]  = mk(1'b1,1'b1,9'h010,16'h1111, 1'b1,1'b1,9'h020,16'h2222, 1'b0,1'b1,1'b1,9'h020,16'h2222, 1'b0,1'b0,16'hBEEF);
    tbl[5]  = mk(1'b1,1'b1,9'h010,16'h1111, 1'b1,1'b1,9'h020,16'h2222, 1'b1,1'b0,1'b1,9'h010,16'h1111, 1'b0,1'b0,16'hBEEF);
    tbl[6]  = mk(1'b1,1'b1,9'h010,16'h1111, 1'b1,1'b1,9'h020,16'h2222, 1'b0,1'b1,1'b1,9'h020,16'h2222, 1'b0,1'b0,16'hBEEF);
    tbl[7]  = mk(1'b1,1'b1,9'h010,16'h1111, 1'b1,1'b1,9'h020,16'h2222, 1'b1,1'b0,1'b1,9'h010,16'h1111, 1'b0,1'b0,16'hBEEF);
    tbl[8]  = mk(1'b1,1'b1,9'h010,16'h1111, 1'b1,1'b1,9'h020,16'h2222, 1'b0,1'b1,1'b1,9'h020,16'h2222, 1'b0,1'b0,16'hBEEF);
    tbl[9]  = mk(1'b1,1'b0,9'h020,16'h0000, 1'b1,1'b0,9'h010,16'h0000, 1'b1,1'b0,1'b0,9'h020,16'h0000, 1'b0,1'b0,16'hBEEF);
    tbl[10] = mk(1'b1,1'b0,9'h1A5,16'h0000, 1'b1,1'b0,9'h010,16'h0000, 1'b0,1'b1,1'b0,9'h010,16'h0000, 1'b1,1'b0,16'h2222);
    tbl[11] = mk(1'b1,1'b0,9'h1A5,16'h0000, 1'b0,1'b0,9'h000,16'h0000, 1'b1,1'b0,1'b0,9'h1A5,16'h0000, 1'b0,1'b1,16'h1111);
    tbl[12] = mk(1'b0,1'b0,9'h000,16'h0000, 1'b0,1'b0,9'h000,16'h0000, 1'b0,1'b0,1'b0,9'h1A5,16'h0000, 1'b1,1'b0,16'hBEEF);
    tbl[13] = mk(1'b0,1'b0,9'h000,16'h0000, 1'b0,1'b0,9'h000,16'h0000, 1'b0,1'b0,1'b0,9'h1A5,16'h0000, 1'b0,1'b0,16'hBEEF);

    // Reset with both requests asserted: nothing may be granted.
    rst_n = 1'b0;
    idle();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; addr0 = 9'h055; wdata0 = 16'h1234;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_gnt0", gnt0, 0);        chk("rst_gnt1", gnt1, 0);
    chk("rst_load", ram_load, 0);    chk("rst_addr", ram_addr, 0);
    chk("rst_in", ram_in, 0);        chk("rst_busy", clr_busy, 0);
    chk("rst_rv0", rvalid0, 0);      chk("rst_rv1", rvalid1, 0);
    chk("rst_rdata", rdata, 0);
    next_cyc();
    rst_n = 1'b1;

    // Directed table; row 0 runs in the first cycle after release.
    for (int i = 0; i < 14; i++) begin
      req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      #4;
      chk($sformatf("tbl%0d_gnt0", i), gnt0, tbl[i].g0);
      chk($sformatf("tbl%0d_gnt1", i), gnt1, tbl[i].g1);
      chk($sformatf("tbl%0d_load", i), ram_load, tbl[i].ld);
      chk($sformatf("tbl%0d_addr", i), ram_addr, tbl[i].ea);
      chk($sformatf("tbl%0d_in", i), ram_in, tbl[i].ei);
      chk($sformatf("tbl%0d_rv0", i), rvalid0, tbl[i].v0);
      chk($sformatf("tbl%0d_rv1", i), rvalid1, tbl[i].v1);
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rd);
      next_cyc();
    end

    // Fill 0/255/511, clear, then read back zeros.
    idle();
    for (int i = 0; i < 3; i++) begin
      req0 = 1'b1; we0 = 1'b1; wdata0 = 16'hFFFF;
      addr0 = (i == 0) ? 9'd0 : (i == 1) ? 9'd255 : 9'd511;
      #4;
      chk("fill_gnt0", gnt0, 1);
      next_cyc();
    end
    idle();
    clr_start = 1'b1;
    #4;
    chk("clr_req_busy", clr_busy, 0);
    next_cyc();
    clr_start = 1'b0;
    busy_n = 0;
    for (int k = 0; k < 600; k++) begin
      #4;
      if (!clr_busy) break;
      if (busy_n == 0)   chk("clr_first_addr", ram_addr, 0);
      if (busy_n == 511) begin
        chk("clr_last_addr", ram_addr, 511);
        chk("clr_last_in", ram_in, 0);
        chk("clr_last_load", ram_load, 1);
      end
      busy_n++;
      next_cyc();
    end
    chk("clr_len", busy_n, 512);
    next_cyc();
    for (int i = 0; i < 3; i++) begin
      req0 = 1'b1; we0 = 1'b0;
      addr0 = (i == 0) ? 9'd0 : (i == 1) ? 9'd255 : 9'd511;
      next_cyc();
      idle();
      #4;
      chk("clr_rd_rv0", rvalid0, 1);
      chk("clr_rd_data", rdata, 0);
      next_cyc();
    end

    // clr_start collides with req0, re-pulse at count 300, req0 served right after.
    idle();
    clr_start = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 9'h033; wdata0 = 16'h0ABC;
    #4;
    chk("coll_gnt0", gnt0, 0);
    chk("coll_load", ram_load, 0);
    next_cyc();
    busy_n = 0;
    for (int k = 0; k < 600; k++) begin
      clr_start = (busy_n == 300);
      #4;
      if (!clr_busy) break;
      if (busy_n == 300) chk("repulse_gnt0", gnt0, 0);
      busy_n++;
      next_cyc();
    end
    chk("repulse_len", busy_n, 512);
    chk("after_clr_gnt0", gnt0, 1);
    next_cyc();
    idle();
    req0 = 1'b1; addr0 = 9'h033;
    next_cyc();
    idle();
    #4;
    chk("after_clr_rv0", rvalid0, 1);
    chk("after_clr_rdata", rdata, 16'h0ABC);
    next_cyc();

    // Reset at count 100 aborts the clear; req1 pending throughout.
    clr_start = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'h033;
    #4;
    chk("clr2_gnt1", gnt1, 0);
    next_cyc();
    clr_start = 1'b0;
    repeat (100) next_cyc();
    #1;
    chk("abort_addr100", ram_addr, 100);
    rst_n = 1'b0;
    #1;
    chk("abort_gnt0", gnt0, 0);     chk("abort_gnt1", gnt1, 0);
    chk("abort_rv0", rvalid0, 0);   chk("abort_rv1", rvalid1, 0);
    chk("abort_rdata", rdata, 0);   chk("abort_addr", ram_addr, 0);
    chk("abort_in", ram_in, 0);     chk("abort_load", ram_load, 0);
    chk("abort_busy", clr_busy, 0);
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
    #4;
    chk("rel_busy", clr_busy, 0);
    chk("rel_gnt1", gnt1, 1);
    next_cyc();
    idle();
    #4;
    chk("rel_rv1", rvalid1, 1);
    next_cyc();

    // Randomized run against the model, starting from reset plus a full clear.
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    m_clr_left = 0; m_ptr = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0;
    m_rdata = '0; m_in = '0; m_addr = '0;
    for (int i = 0; i < NW; i++) m_mem[i] = '0;
    done0 = 1'b0; done1 = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (done0) req0 = 1'b0;
      if (done1) req1 = 1'b0;
      if (!req0 && $urandom_range(0, 3) != 0) begin
        req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        addr0 = $urandom_range(0, 1) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, NW-1));
        wdata0 = 16'($urandom);
      end
      if (!req1 && $urandom_range(0, 3) != 0) begin
        req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        addr1 = $urandom_range(0, 1) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, NW-1));
        wdata1 = 16'($urandom);
      end
      if (cyc == 0)            clr_start = 1'b1;
      else if (m_clr_left > 0) clr_start = ($urandom_range(0, 99) == 0);
      else                     clr_start = ($urandom_range(0, 599) == 0);
      #4;
      e_g0 = 1'b0; e_g1 = 1'b0; e_ld = 1'b0; e_a = m_addr; e_i = m_in;
      e_busy = (m_clr_left > 0);
      if (m_clr_left > 0) begin
        e_ld = 1'b1; e_a = 9'(NW - m_clr_left); e_i = '0;
      end else if (!clr_start) begin
        // req0 wins unless req1 also wants it and it is req1's turn
        if (req0 && (!req1 || !m_ptr)) e_g0 = 1'b1;
        else if (req1)                 e_g1 = 1'b1;
        if (e_g0) begin e_a = addr0; e_i = wdata0; e_ld = we0; end
        if (e_g1) begin e_a = addr1; e_i = wdata1; e_ld = we1; end
      end
      chk("rnd_gnt0", gnt0, e_g0);      chk("rnd_gnt1", gnt1, e_g1);
      chk("rnd_load", ram_load, e_ld);  chk("rnd_addr", ram_addr, e_a);
      chk("rnd_in", ram_in, e_i);       chk("rnd_busy", clr_busy, e_busy);
      chk("rnd_rv0", rvalid0, m_rv0);   chk("rnd_rv1", rvalid1, m_rv1);
      chk("rnd_rdata", rdata, m_rdata);
      m_rv0 = e_g0 && !we0;
      m_rv1 = e_g1 && !we1;
      if (m_rv0 || m_rv1) m_rdata = m_mem[e_a];
      if (e_ld) m_mem[e_a] = e_i;
      if (e_g0) m_ptr = 1'b1;
      if (e_g1) m_ptr = 1'b0;
      m_addr = e_a;
      m_in   = e_i;
      if (m_clr_left > 0) m_clr_left--;
      else if (clr_start) m_clr_left = NW;
      done0 = e_g0;
      done1 = e_g1;
      next_cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ram512_ctrl.md
RAM512_CTRL -- requirements
Module: ram512_ctrl

Interface
REQ-001 The block SHALL use parameter DW, default 16: data word width.
REQ-002 The block SHALL use parameter AW, default 9: address width, giving 512 words.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port req0 / req1, input, 1 bit each: requester 0/1 wants one access; held until granted.
REQ-007 Port we0 / we1, input, 1 bit each: 1 = write, 0 = read; valid while reqN=1.
REQ-008 Port addr0 / addr1, input, AW bits each: word address; valid while reqN=1.
REQ-009 Port wdata0 / wdata1, input, DW bits each: write data; valid while reqN=1 and weN=1.
REQ-010 Port gnt0 / gnt1, output, 1 bit each: access accepted this cycle (combinational).
REQ-011 Port rvalid0 / rvalid1, output, 1 bit each: rdata holds this requester's read result.
REQ-012 Port rdata, output, DW bits: registered read data, shared by both requesters.
REQ-013 Port clr_start, input, 1 bit: request a zero-fill of all 512 words.
REQ-014 Port clr_busy, output, 1 bit: zero-fill in progress.
REQ-015 Ports ram_in (output, DW), ram_addr (output, AW), ram_load (output, 1) and ram_out (input, DW) SHALL connect to the RAM's in/addr/load/out ports; the RAM writes on clk and reads combinationally.

Function
REQ-016 The FSM SHALL have two states: SERVE (default) and CLEAR.
REQ-017 In SERVE, at most one grant per cycle; gnt0 and gnt1 SHALL never both be 1.
REQ-018 With a single active requester, that requester SHALL be granted in the same cycle.
REQ-019 With both active, the side indicated by a 1-bit priority pointer SHALL be granted; after any grant the pointer SHALL point to the non-granted side.
REQ-020 On a grant, ram_addr SHALL equal the granted addrN; ram_load SHALL equal weN; ram_in SHALL equal wdataN.
REQ-021 With no grant, ram_load SHALL be 0; ram_addr and ram_in SHALL hold their last values.
REQ-022 On a read grant, ram_out SHALL be captured into rdata at that clock edge; rvalidN SHALL be 1 for exactly the next cycle (latency 1).
REQ-023 A write grant SHALL leave rdata unchanged and produce no rvalid.
REQ-024 Back-to-back grants SHALL sustain one access per cycle.
REQ-025 If clr_start=1 in SERVE, the FSM SHALL enter CLEAR at the next edge; no grant SHALL issue in that cycle, even with reqN active.
REQ-026 In CLEAR, a 10-bit counter SHALL run 0..511 at one word per cycle, with ram_addr=counter[8:0], ram_in=0, ram_load=1, clr_busy=1, gnt0=gnt1=0.
REQ-027 After writing address 511, the FSM SHALL return to SERVE; the counter SHALL reset to 0. A clear takes exactly 512 cycles.
REQ-028 clr_start in CLEAR SHALL be ignored and SHALL not restart the count.
REQ-029 Pending requests SHALL remain pending through CLEAR and be arbitrated normally in the first SERVE cycle.
REQ-030 An rvalid from a grant made in the cycle before a CLEAR entry SHALL still be delivered.

Reset
REQ-031 While rst_n=0, regardless of clk: state=SERVE, pointer=0, counter=0, rdata=0, rvalid0=rvalid1=0, ram_addr=0, ram_in=0, ram_load=0, clr_busy=0, gnt0=gnt1=0.
REQ-032 Reset asserted mid-CLEAR SHALL abort the clear; RAM contents are then unspecified and no resumption SHALL occur.
REQ-033 The first grant after reset release SHALL be possible in the first cycle with rst_n=1.

Verification
REQ-034 Scenario: req0 writes 0xBEEF at address 0x1A5, then req1 reads 0x1A5 -> gnt0 then gnt1 in consecutive cycles; rvalid1=1 with rdata=0xBEEF one cycle later.
REQ-035 Scenario: req0 and req1 held high for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; gnt0 and gnt1 never both high.
REQ-036 Scenario: fill addresses 0, 255 and 511 with 0xFFFF, pulse clr_start -> clr_busy high for exactly 512 cycles; reads of 0, 255 and 511 return 0x0000.
REQ-037 Scenario: clr_start and req0 in the same cycle -> gnt0=0; req0 is granted in the first cycle after clr_busy falls.
REQ-038 Scenario: rst_n low at count 100 during CLEAR -> all outputs zero immediately; after release, state=SERVE and a request is granted in the first cycle.
REQ-039 Scenario: clr_start re-pulsed at count 300 -> clear still ends 512 cycles after the original start.
